// File: rtl/otter_fetch_if.sv
// otter_fetch_if: hazard/redirect controls, instruction memory port and IF/ID outputs of the fetch stage
interface otter_fetch_if;
  logic        pc_write;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_rden;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
  logic        id_valid;
  modport slave (
    input  pc_write, stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, imem_rden, id_pc, id_pc4, id_instr, id_valid
  );
  modport master (
    output pc_write, stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, imem_rden, id_pc, id_pc4, id_instr, id_valid
  );
endinterface

// File: rtl/otter_fetch_stage.sv
// otter_fetch_stage: OTTER IF stage and IF/ID register with stall hold and redirect squash
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input logic         clk,
  input logic         rst_n,
  otter_fetch_if.slave f
);
  logic [31:0] pc_q, id_pc_q, hold_instr_q;
  logic        id_valid_q, hold_vld_q;
  // PC, IF/ID register and stall hold register; hold keeps the word ID saw once memory moves on
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_VECTOR;
      id_pc_q      <= RESET_VECTOR;
      id_valid_q   <= 1'b0;
      hold_vld_q   <= 1'b0;
      hold_instr_q <= NOP_INSTR;
    end else begin
      pc_q       <= f.redirect_valid ? f.redirect_pc : f.pc_write ? pc_q + 32'd4 : pc_q;
      id_pc_q    <= (f.redirect_valid || f.stall) ? id_pc_q : pc_q;
      id_valid_q <= f.redirect_valid ? 1'b0 : f.stall ? id_valid_q : 1'b1;
      if (f.redirect_valid || !f.stall) hold_vld_q <= 1'b0;
      else if (!hold_vld_q) begin
        hold_vld_q   <= 1'b1;
        hold_instr_q <= f.imem_rdata;
      end
    end
  end
  // outputs: invalid ID shows a NOP, held word overrides live memory data during a stall
  always_comb begin
    f.imem_addr = pc_q;
    f.imem_rden = rst_n;
    f.id_pc     = id_pc_q;
    f.id_pc4    = id_pc_q + 32'd4;
    f.id_valid  = id_valid_q;
    f.id_instr  = !id_valid_q ? NOP_INSTR : hold_vld_q ? hold_instr_q : f.imem_rdata;
  end
endmodule
